// File: rtl/cmp_alarm_fsm.sv
// cmp_alarm_fsm: comparator flag monitor with saturating counts and hysteresis alarm
module cmp_alarm_fsm #(
  parameter int CNT_W   = 8,
  parameter int TRIP    = 3,
  parameter int RELEASE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic             lesser,
  input  logic             greater,
  input  logic             equal,
  input  logic             clear,
  output logic             alarm,
  output logic             alarm_rise,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] gt_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             err
);
  typedef enum logic [1:0] {IDLE = 2'b00, ARMING = 2'b01, ALARM = 2'b10, RELEASING = 2'b11} state_t;
  localparam logic [3:0] TRIP_V = 4'(TRIP);
  localparam logic [3:0] REL_V  = 4'(RELEASE);
  state_t r_state, w_state_nx;
  logic [3:0] r_run, w_run_nx, w_run_inc;
  logic r_rise, r_err, w_rise_nx, w_g, w_l, w_e, w_bad;
  logic [CNT_W-1:0] r_gt, r_lt, r_eq, r_ec;
  assign w_g       = valid & greater & ~lesser & ~equal;
  assign w_l       = valid & lesser & ~greater & ~equal;
  assign w_e       = valid & equal & ~greater & ~lesser;
  assign w_bad     = valid & ~(w_g | w_l | w_e);
  assign w_run_inc = r_run + 4'd1;
  always_comb begin
    w_state_nx = r_state;
    w_run_nx   = r_run;
    case (r_state)
      IDLE:
        if (w_g) begin
          if (TRIP_V == 4'd1) w_state_nx = ALARM;
          else begin
            w_state_nx = ARMING;
            w_run_nx   = 4'd1;
          end
        end
      ARMING:
        if (w_g) begin
          if (w_run_inc == TRIP_V) begin
            w_state_nx = ALARM;
            w_run_nx   = 4'd0;
          end else w_run_nx = w_run_inc;
        end else if (w_l || w_e) begin
          w_state_nx = IDLE;
          w_run_nx   = 4'd0;
        end
      ALARM:
        if (w_l) begin
          if (REL_V == 4'd1) w_state_nx = IDLE;
          else begin
            w_state_nx = RELEASING;
            w_run_nx   = 4'd1;
          end
        end
      RELEASING:
        if (w_l) begin
          if (w_run_inc == REL_V) begin
            w_state_nx = IDLE;
            w_run_nx   = 4'd0;
          end else w_run_nx = w_run_inc;
        end else if (w_g || w_e) begin
          w_state_nx = ALARM;
          w_run_nx   = 4'd0;
        end
    endcase
    // only entries from the non-alarm half of the encoding count as a rise
    w_rise_nx = (w_state_nx == ALARM) && !r_state[1];
  end
  function automatic logic [CNT_W-1:0] f_cnt(input logic [CNT_W-1:0] c, input logic en, input logic clr);
    return clr ? '0 : (en && c != '1) ? c + CNT_W'(1) : c;
  endfunction
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_run   <= '0;
      r_rise  <= 1'b0;
      r_err   <= 1'b0;
      r_gt    <= '0;
      r_lt    <= '0;
      r_eq    <= '0;
      r_ec    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_run   <= w_run_nx;
      r_rise  <= w_rise_nx;
      r_err   <= w_bad;
      r_gt    <= f_cnt(r_gt, w_g, clear);
      r_lt    <= f_cnt(r_lt, w_l, clear);
      r_eq    <= f_cnt(r_eq, w_e, clear);
      r_ec    <= f_cnt(r_ec, w_bad, clear);
    end
  end
  assign state      = r_state;
  assign alarm      = r_state[1];
  assign alarm_rise = r_rise;
  assign err        = r_err;
  assign gt_cnt     = r_gt;
  assign lt_cnt     = r_lt;
  assign eq_cnt     = r_eq;
  assign err_cnt    = r_ec;
endmodule

// File: tb/tb_cmp_alarm_fsm.sv
// tb_cmp_alarm_fsm: vector table, directed corners and a randomized run against a streak-based model
module tb_cmp_alarm_fsm;
  localparam int CW = 4, TR = 3, RL = 2, MX = 15;
  logic clk = 1'b0, rst = 1'b1, valid = 1'b0, lesser = 1'b0, greater = 1'b0, equal = 1'b0, clear = 1'b0;
  logic alarm, alarm_rise, err;
  logic [1:0] state;
  logic [CW-1:0] gt_cnt, lt_cnt, eq_cnt, err_cnt;
  logic [20:0] w_dut;
  int checks = 0, failures = 0;
  cmp_alarm_fsm #(.CNT_W(CW), .TRIP(TR), .RELEASE(RL)) dut (
    .clk(clk), .rst(rst), .valid(valid), .lesser(lesser), .greater(greater), .equal(equal),
    .clear(clear), .alarm(alarm), .alarm_rise(alarm_rise), .state(state), .gt_cnt(gt_cnt),
    .lt_cnt(lt_cnt), .eq_cnt(eq_cnt), .err_cnt(err_cnt), .err(err)
  );
  always #5 clk = ~clk;
  assign w_dut = {state, alarm, alarm_rise, err, gt_cnt, lt_cnt, eq_cnt, err_cnt};
  typedef struct {
    logic r, v, c;
    logic [2:0] f;
    logic [20:0] exp;
  } vec_t;
  vec_t tv[22];
  function automatic vec_t mk(int r, int v, int f, int c, int st, int al, int ri, int er,
                              int gt, int lt, int eq, int ec);
    mk.r = r[0];
    mk.v = v[0];
    mk.f = f[2:0];
    mk.c = c[0];
    mk.exp = {st[1:0], al[0], ri[0], er[0], gt[3:0], lt[3:0], eq[3:0], ec[3:0]};
  endfunction
  task automatic drive(input logic r, input logic v, input logic [2:0] f, input logic c);
    rst = r;
    valid = v;
    {greater, lesser, equal} = f;
    clear = c;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask
  // model: alarm flag plus length of the current qualifying streak
  int m_gt, m_lt, m_eq, m_ec, m_streak;
  logic m_alarm, m_rise, m_err;
  task automatic model(input logic r, input logic v, input logic [2:0] f, input logic c);
    int ones;
    logic bad, g, l, e;
    ones = f[0] + f[1] + f[2];
    bad = v && ones != 1;
    g = v && f == 3'b100;
    l = v && f == 3'b010;
    e = v && f == 3'b001;
    m_rise = 1'b0;
    m_err = 1'b0;
    if (r) begin
      {m_gt, m_lt, m_eq, m_ec, m_streak} = '0;
      m_alarm = 1'b0;
      return;
    end
    m_err = bad;
    if (c) {m_gt, m_lt, m_eq, m_ec} = '0;
    else begin
      if (g && m_gt < MX) m_gt++;
      if (l && m_lt < MX) m_lt++;
      if (e && m_eq < MX) m_eq++;
      if (bad && m_ec < MX) m_ec++;
    end
    if (g || l || e) begin
      if (!m_alarm) begin
        m_streak = g ? m_streak + 1 : 0;
        if (m_streak >= TR) begin
          m_alarm = 1'b1;
          m_rise = 1'b1;
          m_streak = 0;
        end
      end else begin
        m_streak = l ? m_streak + 1 : 0;
        if (m_streak >= RL) begin
          m_alarm = 1'b0;
          m_streak = 0;
        end
      end
    end
  endtask
  function automatic logic [20:0] m_vec();
    return {m_alarm, m_streak != 0, m_alarm, m_rise, m_err, 4'(m_gt), 4'(m_lt), 4'(m_eq), 4'(m_ec)};
  endfunction
  initial begin
    //          r  v  f       c  st    al ri er gt lt eq ec
    tv[0]  = mk(1, 1, 'b111, 0, 'b00, 0, 0, 0, 0, 0, 0, 0);
    tv[1]  = mk(1, 1, 'b100, 1, 'b00, 0, 0, 0, 0, 0, 0, 0);
    tv[2]  = mk(0, 1, 'b100, 0, 'b01, 0, 0, 0, 1, 0, 0, 0);
    tv[3]  = mk(0, 1, 'b100, 0, 'b01, 0, 0, 0, 2, 0, 0, 0);
    tv[4]  = mk(0, 1, 'b100, 0, 'b10, 1, 1, 0, 3, 0, 0, 0);
    tv[5]  = mk(0, 0, 'b010, 0, 'b10, 1, 0, 0, 3, 0, 0, 0);
    tv[6]  = mk(0, 1, 'b010, 0, 'b11, 1, 0, 0, 3, 1, 0, 0);
    tv[7]  = mk(0, 1, 'b100, 0, 'b10, 1, 0, 0, 4, 1, 0, 0);
    tv[8]  = mk(0, 1, 'b010, 0, 'b11, 1, 0, 0, 4, 2, 0, 0);
    tv[9]  = mk(0, 1, 'b010, 0, 'b00, 0, 0, 0, 4, 3, 0, 0);
    tv[10] = mk(0, 1, 'b100, 0, 'b01, 0, 0, 0, 5, 3, 0, 0);
    tv[11] = mk(0, 1, 'b100, 0, 'b01, 0, 0, 0, 6, 3, 0, 0);
    tv[12] = mk(0, 1, 'b001, 0, 'b00, 0, 0, 0, 6, 3, 1, 0);
    tv[13] = mk(0, 1, 'b100, 0, 'b01, 0, 0, 0, 7, 3, 1, 0);
    tv[14] = mk(0, 1, 'b100, 0, 'b01, 0, 0, 0, 8, 3, 1, 0);
    tv[15] = mk(0, 1, 'b110, 0, 'b01, 0, 0, 1, 8, 3, 1, 1);
    tv[16] = mk(0, 0, 'b100, 0, 'b01, 0, 0, 0, 8, 3, 1, 1);
    tv[17] = mk(0, 0, 'b010, 0, 'b01, 0, 0, 0, 8, 3, 1, 1);
    tv[18] = mk(0, 0, 'b111, 0, 'b01, 0, 0, 0, 8, 3, 1, 1);
    tv[19] = mk(0, 1, 'b100, 0, 'b10, 1, 1, 0, 9, 3, 1, 1);
    tv[20] = mk(0, 1, 'b000, 0, 'b10, 1, 0, 1, 9, 3, 1, 2);
    tv[21] = mk(0, 1, 'b011, 0, 'b10, 1, 0, 1, 9, 3, 1, 3);
    for (int i = 0; i < 22; i++) begin
      drive(tv[i].r, tv[i].v, tv[i].f, tv[i].c);
      chk($sformatf("vec%0d", i), w_dut, tv[i].exp);
    end
    repeat (20) drive(0, 1, 3'b100, 0);
    chk("gt_saturate", gt_cnt, 15);
    chk("sat_state", state, 2'b10);
    chk("sat_no_err", {err, err_cnt}, {1'b0, 4'd3});
    drive(0, 1, 3'b010, 1);
    chk("clear_counts", {gt_cnt, lt_cnt, eq_cnt, err_cnt}, 0);
    chk("clear_fsm", {state, alarm}, 3'b111);
    drive(1, 1, 3'b010, 0);
    chk("rst_releasing", w_dut, 0);
    repeat (3) drive(0, 1, 3'b100, 0);
    chk("retrip", w_dut, {2'b10, 1'b1, 1'b1, 1'b0, 4'd3, 12'd0});
    drive(1, 1, 3'b110, 0);
    chk("rst_mid_alarm", w_dut, 0);
    model(1, 0, 3'b000, 0);
    for (int n = 0; n < 3000; n++) begin
      logic r, v, c;
      logic [2:0] f;
      int k;
      r = $urandom_range(99) < 2;
      v = $urandom_range(3) != 0;
      c = $urandom_range(49) == 0;
      k = $urandom_range(9);
      f = ($urandom_range(7) == 0) ? 3'($urandom) : (k < 5) ? 3'b100 : (k < 8) ? 3'b010 : 3'b001;
      model(r, v, f, c);
      drive(r, v, f, c);
      chk($sformatf("rand%0d", n), w_dut, m_vec());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/cmp_alarm_fsm.md
# cmp_alarm_fsm

Sequential monitor placed directly downstream of the 5-bit magnitude comparator. Each cycle it samples the comparator's `lesser`/`greater`/`equal` flags under a `valid` qualifier and keeps saturating per-outcome event counts. A hysteresis state machine raises `alarm` after TRIP consecutive "greater" samples and drops it after RELEASE consecutive "lesser" samples. It also flags malformed (non-one-hot) flag sets.

## Interface
- `CNT_W`, default 8: width of each saturating event counter.
- `TRIP`, default 3: consecutive valid "greater" samples needed to assert `alarm`. Legal range 1..15.
- `RELEASE`, default 2: consecutive valid "lesser" samples needed to deassert `alarm`. Legal range 1..15.

Clock and reset: one clock; reset is synchronous and active-high.

- `clk` in, 1: single clock; all state changes on the rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `valid` in, 1: flags are sampled this cycle.
- `lesser` in, 1: comparator flag, a < b.
- `greater` in, 1: comparator flag, a > b.
- `equal` in, 1: comparator flag, a == b.
- `clear` in, 1: synchronous clear of the counters and `err_cnt`.
- `alarm` out, 1: high in ALARM and RELEASING.
- `alarm_rise` out, 1: one-cycle pulse on entry to ALARM from IDLE or ARMING.
- `state` out, 2: IDLE=00, ARMING=01, ALARM=10, RELEASING=11.
- `gt_cnt` out, CNT_W: count of valid "greater" samples.
- `lt_cnt` out, CNT_W: count of valid "lesser" samples.
- `eq_cnt` out, CNT_W: count of valid "equal" samples.
- `err_cnt` out, CNT_W: count of valid samples whose flags are not exactly one-hot.
- `err` out, 1: one-cycle pulse, registered, for a malformed sample.

## Operation
**Sample classes** (valid=1 only; valid=0 changes nothing except `clear`):
- G: the flags are exactly 100 in the order greater/lesser/equal.
- L: exactly 010.
- E: exactly 001.
- BAD: any other combination (000, or two or more flags set).
- BAD increments `err_cnt` and pulses `err`. It leaves the FSM, the run counter and the G/L/E counters untouched.

**Counters:**
- G, L and E increment `gt_cnt`, `lt_cnt` and `eq_cnt` respectively.
- All counters, including `err_cnt`, saturate at 2^CNT_W-1 and never wrap.

**Run counter:** internal, 4 bits. It counts consecutive qualifying samples within ARMING and RELEASING, and is zero in every other state.

**FSM transitions** (evaluated only on a G, L or E sample):
- IDLE:
  - G moves to ARMING with run=1, or straight to ALARM if TRIP=1.
  - L and E stay in IDLE.
- ARMING:
  - G increments run; reaching TRIP moves to ALARM with run=0.
  - L or E moves to IDLE with run=0.
- ALARM:
  - L moves to RELEASING with run=1, or straight to IDLE if RELEASE=1.
  - G and E stay in ALARM.
- RELEASING:
  - L increments run; reaching RELEASE moves to IDLE with run=0.
  - G or E moves to ALARM with run=0.

**Outputs:**
- `alarm_rise` is high for exactly the one cycle following the transition edge into ALARM from IDLE or ARMING.
- It is not asserted on RELEASING→ALARM.

**Clear:**
- `clear` zeroes gt/lt/eq/err counts. It does not affect the FSM or the run counter.
- When `clear` and `valid` are high together, clear wins for the counters, which read 0 next cycle. The FSM still processes the sample.

**Reset:**
- `rst` overrides everything: state IDLE, run 0, and all outputs 0.
- Reset mid-alarm drops `alarm` on the next edge, with no `alarm_rise` and no `err`.

## Timing
- Every output is a flop output with no combinational path from the inputs.
- Latency is 1 cycle: a sample presented with valid in cycle n is reflected in the counters, `state`, `alarm` and `err` in cycle n+1.
- With TRIP=3, `alarm` rises in the cycle after the edge that sampled the 3rd consecutive G.
- Reset values: `alarm`=0, `alarm_rise`=0, `state`=00, `err`=0, and all counts 0.
- Valid-low cycles do not break a run. ARMING and RELEASING wait indefinitely for the next valid sample.
- Counters saturate: at max value they hold and raise no error.

## Test plan
All scenarios use TRIP=3, RELEASE=2, CNT_W=4.
- **Reset:** assert rst for 2 cycles with flags random → all outputs 0 and state=00.
- **Trip:** G,G,G valid back-to-back → state goes 01,01,10; `alarm`=1 and `alarm_rise` pulses once; `gt_cnt`=3.
- **Broken arm:** G,G,E,G → state ends at 01, `alarm`=0, `gt_cnt`=3, `eq_cnt`=1.
- **Release and re-trigger:**
  - From ALARM, L,G → state 11 then 10; `alarm` stays 1 and there is no `alarm_rise`.
  - Then L,L → state 00 and `alarm`=0.
- **Malformed and gaps:**
  - In ARMING with run=2, BAD (110), then valid=0 for 3 cycles, then G → ALARM.
  - Result: `err` pulses once and `err_cnt`=1.
- **Saturation, clear and reset:**
  - 20 valid G samples → `gt_cnt`=15.
  - `clear` together with a valid L → `lt_cnt`=0 and `gt_cnt`=0, while the FSM enters RELEASING.
  - `rst` → state 00 and `alarm`=0 next cycle.
